vt_sensor_readout: RTL and testbench
====================================

# vt_sensor_readout

Digital-domain reader for the ripple-counter VT sensor. It runs on the system clock and drives the sensor's ENIN 4-pulse conversion protocol. It synchronizes the sensor's TXDV/ENOUT status lines, captures and de-inverts the sensor count, and averages 1/2/4/8 conversions. The result is presented on a valid/ready port to the sensor register bank.

## Interface
Parameters:
- CNT_W, 16, sensor count width
- WIN_W, 16, window-length field width
- PULSE_CYC, 4, high time of ENIN pulses 1, 3, 4 in CLK cycles (≥3)
- GAP_CYC, 4, ENIN low time after pulses 1, 3, 4 (≥2)
- TO_CYC, 16, TXDV timeout in CLK cycles

Ports:
- CLK  in  1  system clock
- RSTHIGH  in  1  reset, asynchronous, active-high; also wired to the sensor reset
- START  in  1  one-cycle request, honoured in IDLE only
- WIN_CYC  in  WIN_W  ENIN pulse-2 high time (measurement window); 0 treated as 1
- AVG_SEL  in  2  log2 of samples per result; sampled at START
- ENIN  out  1  sensor enable/sequence strobe, registered
- TXDV  in  1  sensor data-valid, asynchronous
- ENOUT  in  1  sensor phase-3 flag, asynchronous
- CNT  in  CNT_W  sensor count, ones-complement encoded, stable while TXDV=1
- BUSY  out  1  conversion in progress
- DOUT  out  CNT_W  averaged edge count
- DVALID  out  1  DOUT valid, held until DREADY
- DREADY  in  1  consumer accept
- ERR  out  1  sticky protocol error, cleared by next accepted START

## Operation
- Sensor protocol per sample: 4 ENIN rising edges advance sensor phase 00→10→01→11→00.
  - Pulse 1 low phase resets the sensor counter.
  - Pulse 2 high phase is the count window.
  - Pulse 2 low phase asserts TXDV.
  - Pulse 3 high sets ENOUT.
  - Pulse 4 returns the sensor to phase 00.
- FSM states:
  - IDLE → P1H on START, latching AVG_SEL, WIN_CYC and clearing the accumulator and ERR.
  - P1H (PULSE_CYC) → P1L (GAP_CYC) → P2H (WIN_CYC).
  - P2H → P2L (wait/capture).
  - P2L → P3H (PULSE_CYC; check ENOUT) → P3L (GAP_CYC) → P4H (PULSE_CYC) → P4L (GAP_CYC).
  - P4L → P1H if samples remain, else DONE.
  - DONE → IDLE on DVALID&DREADY.
- ENIN=1 exactly in P1H, P2H, P3H, P4H.
- TXDV and ENOUT each pass through a 2-flop synchronizer (txdv_s, enout_s).
- Capture in P2L:
  - On the second consecutive cycle with txdv_s=1, sample = ~CNT (bitwise invert).
  - acc += sample, then go to P3H.
- Accumulator width is CNT_W+3, so there is no overflow at 8 samples. DOUT = acc >> AVG_SEL (truncating).
- Errors:
  - TXDV timeout: P2L exceeds TO_CYC cycles without capture. ERR=1, ENIN=0, go to IDLE with no DVALID.
  - ENOUT check: enout_s=0 in the last P3H cycle. ERR=1, finish P3L/P4H/P4L, then go to IDLE with no DVALID.
- START outside IDLE is ignored, including in DONE.
- DREADY outside DONE is ignored.

## Timing
- Reset values: ENIN=0, BUSY=0, DVALID=0, DOUT=0, ERR=0, synchronizers=0, FSM=IDLE.
- RSTHIGH mid-conversion aborts immediately. The sensor resets in the same event, so phase alignment is preserved.
- ENIN rises in the first P1H cycle, i.e. the CLK edge after the START cycle.
- BUSY=1 from that edge until DVALID is set (or ERR abort).
- Per-sample length: 3·PULSE_CYC + 3·GAP_CYC + WIN_CYC + P2L length. P2L is 3 cycles nominal with sensor delay < 1 CLK.
- DVALID and DOUT update on the same edge on DONE entry. DOUT holds until the next result.
- DVALID falls on the edge after DVALID&DREADY.
- ERR sets on the edge of detection and stays set until the next accepted START.

## Structure
- Shared package vt_readout_pkg holds:
  - the state enum (IDLE, P1H, P1L, P2H, P2L, P3H, P3L, P4H, P4L, DONE);
  - default CNT_W, WIN_W, PULSE_CYC, GAP_CYC, TO_CYC localparams.
- Sub-module sync2 (2-flop, async reset to 0), instantiated for TXDV and ENOUT.
- Single phase-timer counter, reloaded on each state entry.
- Sample counter of 3 bits.

## Test plan
All scenarios use a bench sensor model: 4-phase ENIN logic, gated oscillator at 4× CLK, ones-complement CNT.
- Single sample: AVG_SEL=0, WIN_CYC=100, START → ENIN pulse widths 4/100/4/4 with 4-cycle gaps; DOUT=400 (±4), DVALID held until DREADY, BUSY and ENIN low afterwards.
- Averaging: AVG_SEL=3, WIN_CYC=50, oscillator 3× → 8 pulse-2 windows, DOUT=150 (±3), single DVALID.
- Backpressure: DREADY=0 for 20 cycles after DVALID; START pulsed in DONE → ignored; DVALID/DOUT stable; IDLE one cycle after DREADY.
- TXDV stuck low: model never asserts TXDV → after 16 P2L cycles ERR=1, ENIN=0, BUSY=0, no DVALID; next START clears ERR.
- ENOUT missing: model holds ENOUT=0 → ERR=1 after pulse 3, pulse 4 still issued, no DVALID.
- Reset mid-window: RSTHIGH during P2H → ENIN=0, FSM=IDLE, sensor phase 00; following START with WIN_CYC=0 → 1-cycle window, DOUT=4 (±4).

Source files
------------

// File: rtl/vt_readout_pkg.sv
// Shared state encoding and default sizing for the VT sensor readout block.
package vt_readout_pkg;

  localparam int DEF_CNT_W     = 16;
  localparam int DEF_WIN_W     = 16;
  localparam int DEF_PULSE_CYC = 4;
  localparam int DEF_GAP_CYC   = 4;
  localparam int DEF_TO_CYC    = 16;

  typedef enum logic [3:0] {
    IDLE, P1H, P1L, P2H, P2L, P3H, P3L, P4H, P4L, DONE
  } state_t;

endpackage

// File: rtl/vt_sensor_readout_sync2.sv
// Two-flop synchronizer for asynchronous sensor status lines; 2 CLK latency,
// no backpressure.
module sync2 (
  input  logic CLK,
  input  logic RSTHIGH,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK or posedge RSTHIGH) begin
    if (RSTHIGH) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vt_sensor_readout.sv
// Sequences the sensor's 4-pulse ENIN protocol, captures and averages 1-8 counts.
// Result is held on DVALID until DREADY; a new START is ignored until then.
module vt_sensor_readout
  import vt_readout_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int WIN_W     = DEF_WIN_W,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int TO_CYC    = DEF_TO_CYC
) (
  input  logic             CLK,
  input  logic             RSTHIGH,
  input  logic             START,
  input  logic [WIN_W-1:0] WIN_CYC,
  input  logic [1:0]       AVG_SEL,
  output logic             ENIN,
  input  logic             TXDV,
  input  logic             ENOUT,
  input  logic [CNT_W-1:0] CNT,
  output logic             BUSY,
  output logic [CNT_W-1:0] DOUT,
  output logic             DVALID,
  input  logic             DREADY,
  output logic             ERR
);

  localparam int ACC_W = CNT_W + 3;

  state_t             state, state_nx;
  logic [WIN_W-1:0]   tmr, tmr_load, win_q;
  logic [1:0]         avg_q;
  logic [2:0]         smp_cnt;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   avg_res;
  logic               txdv_s, enout_s, txdv_d;
  logic               tmr_end, smp_last;
  logic               start_ok, capture, timeout, enout_bad;

  sync2 u_sync_txdv  (.CLK(CLK), .RSTHIGH(RSTHIGH), .d(TXDV),  .q(txdv_s));
  sync2 u_sync_enout (.CLK(CLK), .RSTHIGH(RSTHIGH), .d(ENOUT), .q(enout_s));

  assign tmr_end  = (tmr == '0);
  // Wraps modulo 8, so AVG_SEL=3 compares against 7.
  assign smp_last = (smp_cnt == ((3'd1 << avg_q) - 3'd1));

  always_comb begin
    state_nx  = state;
    start_ok  = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    enout_bad = 1'b0;
    case (state)
      IDLE: if (START) begin
        state_nx = P1H;
        start_ok = 1'b1;
      end
      P1H: if (tmr_end) state_nx = P1L;
      P1L: if (tmr_end) state_nx = P2H;
      P2H: if (tmr_end) state_nx = P2L;
      P2L: begin
        // Two consecutive synchronized highs guarantee CNT has settled.
        if (txdv_s && txdv_d) begin
          capture  = 1'b1;
          state_nx = P3H;
        end else if (tmr_end) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      P3H: if (tmr_end) begin
        enout_bad = !enout_s;
        state_nx  = P3L;
      end
      P3L: if (tmr_end) state_nx = P4H;
      P4H: if (tmr_end) state_nx = P4L;
      P4L: if (tmr_end) begin
        if (ERR)           state_nx = IDLE;
        else if (smp_last) state_nx = DONE;
        else               state_nx = P1H;
      end
      DONE: if (DREADY) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tmr_load = '0;
    case (state_nx)
      P1H, P3H, P4H: tmr_load = WIN_W'(PULSE_CYC - 1);
      P1L, P3L, P4L: tmr_load = WIN_W'(GAP_CYC - 1);
      P2H:           tmr_load = (win_q == '0) ? '0 : win_q - WIN_W'(1);
      P2L:           tmr_load = WIN_W'(TO_CYC - 1);
      default:       tmr_load = '0;
    endcase
  end

  always_comb begin
    case (avg_q)
      2'd0:    avg_res = acc[CNT_W-1:0];
      2'd1:    avg_res = acc[CNT_W:1];
      2'd2:    avg_res = acc[CNT_W+1:2];
      default: avg_res = acc[CNT_W+2:3];
    endcase
  end

  always_ff @(posedge CLK or posedge RSTHIGH) begin
    if (RSTHIGH) begin
      state   <= IDLE;
      tmr     <= '0;
      win_q   <= '0;
      avg_q   <= '0;
      smp_cnt <= '0;
      acc     <= '0;
      txdv_d  <= 1'b0;
      ENIN    <= 1'b0;
      DOUT    <= '0;
      ERR     <= 1'b0;
    end else begin
      state  <= state_nx;
      tmr    <= (state_nx != state) ? tmr_load : tmr - WIN_W'(1);
      txdv_d <= txdv_s;
      ENIN   <= (state_nx inside {P1H, P2H, P3H, P4H});
      if (start_ok) begin
        win_q   <= WIN_CYC;
        avg_q   <= AVG_SEL;
        acc     <= '0;
        smp_cnt <= '0;
        ERR     <= 1'b0;
      end
      if (capture)               acc     <= acc + {3'b000, ~CNT};
      if (timeout || enout_bad)  ERR     <= 1'b1;
      if (state == P4L && state_nx == P1H) smp_cnt <= smp_cnt + 3'd1;
      if (state != DONE && state_nx == DONE) DOUT <= avg_res;
    end
  end

  assign BUSY   = (state != IDLE) && (state != DONE);
  assign DVALID = (state == DONE);

endmodule

// File: tb/tb_vt_sensor_readout.sv
// Bench for vt_sensor_readout: behavioural ripple-counter sensor model plus
// vector table, randomized averaging runs and hand-written error/reset sequences.
module tb_vt_sensor_readout;

  logic        CLK = 1'b0;
  logic        RSTHIGH;
  logic        START;
  logic [15:0] WIN_CYC;
  logic [1:0]  AVG_SEL;
  logic        ENIN;
  logic        TXDV;
  logic        ENOUT;
  logic [15:0] CNT;
  logic        BUSY;
  logic [15:0] DOUT;
  logic        DVALID;
  logic        DREADY;
  logic        ERR;

  int checks = 0;
  int errors = 0;

  vt_sensor_readout dut (
    .CLK(CLK), .RSTHIGH(RSTHIGH), .START(START), .WIN_CYC(WIN_CYC),
    .AVG_SEL(AVG_SEL), .ENIN(ENIN), .TXDV(TXDV), .ENOUT(ENOUT), .CNT(CNT),
    .BUSY(BUSY), .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // ---------------- sensor model ----------------
  int          ph = 0;
  int          smp_idx = 0;
  int          cur_mult = 4;
  int          mult_arr [256];
  logic [15:0] cnt_r = '0;
  bit          txdv_kill = 1'b0;
  bit          enout_kill = 1'b0;
  logic        sens_rst = 1'b0;

  always @(posedge ENIN or posedge RSTHIGH or posedge sens_rst) begin
    if (RSTHIGH || sens_rst) ph = 0;
    else begin
      ph = (ph + 1) % 4;
      if (ph == 1) begin
        cur_mult = mult_arr[smp_idx % 256];
        smp_idx++;
      end
    end
  end

  // Oscillator of cur_mult edges per CLK, gated by the pulse-2 window.
  always @(negedge CLK or posedge RSTHIGH) begin
    if (RSTHIGH)                cnt_r = '0;
    else if (ph == 1 && !ENIN)  cnt_r = '0;
    else if (ph == 2 && ENIN)   cnt_r = cnt_r + 16'(cur_mult);
  end

  assign TXDV  = !txdv_kill && (ph == 2) && !ENIN;
  assign ENOUT = !enout_kill && (ph == 3);
  assign CNT   = ~cnt_r;

  // ---------------- helpers ----------------
  typedef struct packed {
    int avg;
    int win;
    int mult;
    int exp_dout;
  } vec_t;

  vec_t tbl [6];
  bit   enin_log [$];
  int   hi_w [$];
  int   lo_w [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_sample(input int win, input int mult);
    return ((win == 0) ? 1 : win) * mult;
  endfunction

  task automatic set_mults(input int n, input int m);
    for (int i = 0; i < n; i++) mult_arr[(smp_idx + i) % 256] = m;
  endtask

  task automatic start_conv(input int avg, input int win, input string tag);
    AVG_SEL = 2'(avg);
    WIN_CYC = 16'(win);
    START   = 1'b1;
    @(negedge CLK);
    START   = 1'b0;
    chk({tag, "_enin_rise"}, ENIN, 1);
    chk({tag, "_busy_rise"}, BUSY, 1);
    chk({tag, "_err_clear"}, ERR, 0);
  endtask

  task automatic wait_idle(input int budget, input string tag, output int busy_cyc);
    busy_cyc = 0;
    enin_log.delete();
    while (BUSY && busy_cyc < budget) begin
      enin_log.push_back(ENIN);
      @(negedge CLK);
      busy_cyc++;
    end
    if (BUSY) chk({tag, "_wait_budget"}, busy_cyc, -1);
  endtask

  task automatic enin_runs();
    int r = 1;
    hi_w.delete();
    lo_w.delete();
    for (int i = 1; i < enin_log.size(); i++) begin
      if (enin_log[i] == enin_log[i-1]) r++;
      else begin
        if (enin_log[i-1]) hi_w.push_back(r); else lo_w.push_back(r);
        r = 1;
      end
    end
    if (enin_log.size() > 0) begin
      if (enin_log[enin_log.size()-1]) hi_w.push_back(r); else lo_w.push_back(r);
    end
  endtask

  task automatic run_conv(input int avg, input int win, input int exp_dout,
                          input bit hold_rdy, input string tag);
    int bc;
    DREADY = hold_rdy;
    start_conv(avg, win, tag);
    wait_idle((1 << avg) * (win + 50) + 50, tag, bc);
    chk({tag, "_dvalid"}, DVALID, 1);
    chk({tag, "_dout"}, DOUT, exp_dout);
    chk({tag, "_err"}, ERR, 0);
    DREADY = 1'b1;
    @(negedge CLK);
    DREADY = 1'b0;
    chk({tag, "_dvalid_fall"}, DVALID, 0);
    chk({tag, "_idle_enin"}, ENIN, 0);
    chk({tag, "_idle_busy"}, BUSY, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    int bc, bad, avg, win, n, sum;
    string tag;

    tbl[0] = '{avg: 0, win: 100,   mult: 4, exp_dout: 400};
    tbl[1] = '{avg: 3, win: 50,    mult: 3, exp_dout: 150};
    tbl[2] = '{avg: 1, win: 10,    mult: 2, exp_dout: 20};
    tbl[3] = '{avg: 2, win: 7,     mult: 1, exp_dout: 7};
    tbl[4] = '{avg: 0, win: 0,     mult: 4, exp_dout: 4};
    tbl[5] = '{avg: 1, win: 12000, mult: 5, exp_dout: 60000};

    for (int i = 0; i < 256; i++) mult_arr[i] = 4;
    RSTHIGH = 1'b1; START = 1'b0; WIN_CYC = '0; AVG_SEL = '0; DREADY = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_enin", ENIN, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_dvalid", DVALID, 0);
    chk("rst_dout", DOUT, 0);
    chk("rst_err", ERR, 0);
    RSTHIGH = 1'b0;
    @(negedge CLK);

    // Vector table; first entry also checks the ENIN pulse train shape.
    for (int i = 0; i < 6; i++) begin
      tag = $sformatf("tbl%0d", i);
      set_mults(1 << tbl[i].avg, tbl[i].mult);
      run_conv(tbl[i].avg, tbl[i].win, tbl[i].exp_dout, 1'b0, tag);
      if (i == 0) begin
        enin_runs();
        chk("p_hi_count", hi_w.size(), 4);
        chk("p_lo_count", lo_w.size(), 4);
        if (hi_w.size() == 4 && lo_w.size() == 4) begin
          chk("p1_high", hi_w[0], 4);
          chk("p2_high", hi_w[1], 100);
          chk("p3_high", hi_w[2], 4);
          chk("p4_high", hi_w[3], 4);
          chk("p1_gap", lo_w[0], 4);
          chk("p3_gap", lo_w[2], 4);
          chk("p4_gap", lo_w[3], 4);
        end
      end
    end

    // Randomized averaging with per-sample oscillator rates, DREADY held high.
    for (int t = 0; t < 6; t++) begin
      avg = $urandom_range(3, 0);
      win = $urandom_range(60, 0);
      n   = 1 << avg;
      sum = 0;
      for (int s = 0; s < n; s++) begin
        mult_arr[(smp_idx + s) % 256] = $urandom_range(4, 1);
        sum += ref_sample(win, mult_arr[(smp_idx + s) % 256]);
      end
      tag = $sformatf("rnd%0d", t);
      run_conv(avg, win, sum / n, 1'b1, tag);
    end

    // Backpressure: result held, START in DONE ignored.
    set_mults(1, 4);
    start_conv(0, 20, "bp");
    wait_idle(200, "bp", bc);
    chk("bp_dvalid", DVALID, 1);
    chk("bp_dout", DOUT, 80);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin START = 1'b1; WIN_CYC = 16'd3; end
      @(negedge CLK);
      START = 1'b0;
      if (DVALID !== 1'b1 || DOUT !== 16'd80 || BUSY !== 1'b0) bad++;
    end
    chk("bp_hold_bad_cycles", bad, 0);
    DREADY = 1'b1;
    @(negedge CLK);
    DREADY = 1'b0;
    chk("bp_dvalid_fall", DVALID, 0);
    @(negedge CLK);
    chk("bp_start_ignored_busy", BUSY, 0);
    chk("bp_start_ignored_enin", ENIN, 0);

    // TXDV stuck low: abort after 4+4+10 cycles plus 16 in P2L.
    txdv_kill = 1'b1;
    set_mults(1, 4);
    start_conv(0, 10, "to");
    wait_idle(200, "to", bc);
    chk("to_busy_cycles", bc, 34);
    chk("to_err", ERR, 1);
    chk("to_enin", ENIN, 0);
    chk("to_busy", BUSY, 0);
    chk("to_no_dvalid", DVALID, 0);
    txdv_kill = 1'b0;
    sens_rst = 1'b1;
    #1 sens_rst = 1'b0;
    @(negedge CLK);
    chk("to_err_sticky", ERR, 1);
    set_mults(1, 2);
    run_conv(0, 9, 18, 1'b0, "to_recover");

    // ENOUT missing: all four pulses still issued, no result.
    enout_kill = 1'b1;
    set_mults(1, 4);
    start_conv(0, 10, "eo");
    wait_idle(200, "eo", bc);
    enin_runs();
    chk("eo_pulses", hi_w.size(), 4);
    chk("eo_err", ERR, 1);
    chk("eo_no_dvalid", DVALID, 0);
    chk("eo_enin", ENIN, 0);
    enout_kill = 1'b0;
    @(negedge CLK);
    set_mults(1, 3);
    run_conv(0, 5, 15, 1'b0, "eo_recover");

    // Reset in the middle of the pulse-2 window.
    set_mults(1, 4);
    start_conv(0, 200, "rw");
    repeat (15) @(negedge CLK);
    RSTHIGH = 1'b1;
    #1;
    chk("rw_enin", ENIN, 0);
    chk("rw_busy", BUSY, 0);
    chk("rw_dvalid", DVALID, 0);
    chk("rw_sensor_phase", ph, 0);
    @(negedge CLK);
    RSTHIGH = 1'b0;
    @(negedge CLK);
    set_mults(1, 4);
    run_conv(0, 0, 4, 1'b0, "rw_win0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
